seq_alu: RTL

Parametrised multi-cycle successor to the combinational calculator ALU: captures two WIDTH-bit operands and a 4-bit opcode on a rising edge of the `go` request, executes ADD/SUB in one cycle and MUL/DIV/MOD iteratively over WIDTH cycles, and holds a registered 2·WIDTH-bit result. It sits between the keypad/pushbutton operand capture logic and the display formatter. It replaces the single-cycle divider and multiplier with a shift-based datapath, adds a busy/done handshake, and flags divide-by-zero and illegal opcodes.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/seq_muldiv_core.sv | 91 +++++++++
 rtl/seq_alu.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential calculator ALU: opcode encoding
// and the controller state encoding.
package alu_pkg;

    localparam int OPCODE_WIDTH = 4;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_DIV = 4'd3,
        OP_MUL = 4'd4,
        OP_MOD = 4'd5
    } alu_opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } alu_state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative datapath: LSB-first shift-add multiplier and restoring divider.
// 'load' primes both engines from the operands, each 'step' performs one
// iteration of both; after WIDTH steps prod_o, quo_o and rem_o are final.
module seq_muldiv_core #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   prod_o,
    output logic [WIDTH-1:0]     quo_o,
    output logic [WIDTH-1:0]     rem_o
);

    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   dvsr_q,   dvsr_d;
    logic [WIDTH-1:0]   rem_q,    rem_d;
    logic [WIDTH-1:0]   quo_q,    quo_d;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH:0]     trial_s;

    // Next-state logic for one multiply iteration and one restoring-divide iteration.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        dvsr_d   = dvsr_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        // Shift the next dividend bit into the partial remainder, then try to subtract.
        rem_sh_s = {rem_q, quo_q[WIDTH-1]};
        trial_s  = rem_sh_s - {1'b0, dvsr_q};
        if (load) begin
            acc_d    = {(2*WIDTH){1'b0}};
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            dvsr_d   = b_i;
            rem_d    = {WIDTH{1'b0}};
            quo_d    = a_i;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end else begin
                acc_d = acc_q;
            end
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            // A clear sign bit means the divisor fitted: keep the difference, quotient bit 1.
            if (!trial_s[WIDTH]) begin
                rem_d = trial_s[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = rem_sh_s[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d    = acc_q;
            mcand_d  = mcand_q;
            mplier_d = mplier_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            dvsr_q   <= {WIDTH{1'b0}};
            rem_q    <= {WIDTH{1'b0}};
            quo_q    <= {WIDTH{1'b0}};
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            dvsr_q   <= dvsr_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
        end
    end

    assign prod_o = acc_q;
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle calculator ALU: go edge detector, IDLE/RUN/FINISH controller,
// iteration counter, single-cycle ADD/SUB and the registered result/err/done/busy.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic [WIDTH-1:0]     val_a,
    input  logic [WIDTH-1:0]     val_b,
    input  logic [3:0]           op,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    alu_state_t               state_q,  state_d;
    logic                     go_q,     go_d;
    logic [CNT_W-1:0]         cnt_q,    cnt_d;
    logic [WIDTH-1:0]         a_q,      a_d;
    logic [WIDTH-1:0]         b_q,      b_d;
    logic [3:0]               op_q,     op_d;
    logic [2*WIDTH-1:0]       result_q, result_d;
    logic                     err_q,    err_d;
    logic                     done_q,   done_d;
    logic                     busy_q,   busy_d;

    logic                     go_rise_s;
    logic                     b_zero_s;
    logic                     is_iter_s;
    logic                     load_s;
    logic                     step_s;
    logic [2*WIDTH-1:0]       a_ext_s;
    logic [2*WIDTH-1:0]       b_ext_s;
    logic [2*WIDTH-1:0]       prod_s;
    logic [WIDTH-1:0]         quo_s;
    logic [WIDTH-1:0]         rem_s;

    seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_s),
        .step   (step_s),
        .a_i    (val_a),
        .b_i    (val_b),
        .prod_o (prod_s),
        .quo_o  (quo_s),
        .rem_o  (rem_s)
    );

    // Controller next-state, counter and result/err computation.
    always_comb begin
        go_d      = go;
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        err_d     = err_q;
        done_d    = 1'b0;
        load_s    = 1'b0;
        step_s    = 1'b0;
        go_rise_s = go & ~go_q;
        b_zero_s  = (b_q == {WIDTH{1'b0}});
        // MUL always iterates; DIV/MOD only when the divisor is usable.
        is_iter_s = (op_q == OP_MUL) ||
                    (((op_q == OP_DIV) || (op_q == OP_MOD)) && !b_zero_s);
        a_ext_s   = {{WIDTH{1'b0}}, a_q};
        b_ext_s   = {{WIDTH{1'b0}}, b_q};
        case (state_q)
            ST_IDLE: begin
                if (go_rise_s) begin
                    a_d     = val_a;
                    b_d     = val_b;
                    op_d    = op;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    load_s  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!is_iter_s) begin
                    state_d = ST_FINISH;
                end else if (cnt_q == {CNT_W{1'b0}}) begin
                    step_s  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    step_s  = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = ST_RUN;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                case (op_q)
                    OP_ADD: begin
                        result_d = a_ext_s + b_ext_s;
                        err_d    = 1'b0;
                    end
                    OP_SUB: begin
                        result_d = a_ext_s - b_ext_s;
                        err_d    = 1'b0;
                    end
                    OP_MUL: begin
                        result_d = prod_s;
                        err_d    = 1'b0;
                    end
                    OP_DIV: begin
                        if (b_zero_s) begin
                            result_d = {(2*WIDTH){1'b0}};
                            err_d    = 1'b1;
                        end else begin
                            result_d = {rem_s, quo_s};
                            err_d    = 1'b0;
                        end
                    end
                    OP_MOD: begin
                        if (b_zero_s) begin
                            result_d = {(2*WIDTH){1'b0}};
                            err_d    = 1'b1;
                        end else begin
                            result_d = {{WIDTH{1'b0}}, rem_s};
                            err_d    = 1'b0;
                        end
                    end
                    default: begin
                        result_d = {(2*WIDTH){1'b0}};
                        err_d    = 1'b1;
                    end
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // busy stays up through the cycle where done is shown.
        busy_d = (state_d != ST_IDLE) || done_d;
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            go_q     <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            op_q     <= 4'd0;
            result_q <= {(2*WIDTH){1'b0}};
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            go_q     <= go_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign result = result_q;
    assign err    = err_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule
